writeback_unit: RTL and testbench

- Final pipeline stage; drives the single write port of the `registers` block.
- Merges two result sources into that one port:
  - ALU results from execute, with valid/ready handshake.
  - Load responses from the data-memory interface, which cannot be stalled.
- Aligns and extends load data, suppresses writes to x0, and holds one blocked ALU result.

---
 rtl/wb_pkg.sv | 9 +
 rtl/writeback_unit_load_formatter.sv | 24 ++
 rtl/writeback_unit.sv | 105 ++++++++++
 tb/tb_writeback_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings and defaults for the writeback unit.
package wb_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic {IDLE, HOLD} state_e;
endpackage

// File: rtl/writeback_unit_load_formatter.sv
// load_formatter: selects the addressed lane of a load word and sign/zero-extends it.
module load_formatter
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] mem_data,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [1:0]        mem_off,
  output logic [DATA_W-1:0] data_o,
  output logic              misalign_o
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = mem_data[8*mem_off +: 8];
  assign h = mem_off[1] ? mem_data[31:16] : mem_data[15:0];
  always_comb begin
    data_o = mem_size == SZ_BYTE ? {{(DATA_W-8){~mem_unsigned & b[7]}}, b} :
             mem_size == SZ_HALF ? {{(DATA_W-16){~mem_unsigned & h[15]}}, h} : mem_data;
    misalign_o = mem_size == SZ_HALF ? mem_off[0] :
                 mem_size == SZ_WORD ? (mem_off != 2'b00) : (mem_size != SZ_BYTE);
  end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU results and unstallable load responses onto the register write port.
// Optional WB_FWD_EN adds a bypass of the registered write port to decode.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [1:0]        mem_off,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              mem_misalign
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              fwd1_valid,
  output logic [DATA_W-1:0] fwd1_data,
  output logic              fwd2_valid,
  output logic [DATA_W-1:0] fwd2_data
`endif
);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   hold_rd_q, hold_rd_d, waddr_q, waddr_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d, wdata_q, wdata_d, ld;
  logic                we_q, we_d, mis_q, mis_d, mis, acc;
  load_formatter #(.DATA_W(DATA_W)) u_fmt (
    .mem_data(mem_data), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .mem_off(mem_off), .data_o(ld), .misalign_o(mis)
  );
  assign ex_ready = state_q == IDLE;
  assign acc = ex_valid && ex_ready;
  always_comb begin
    state_d = state_q;
    hold_rd_d = hold_rd_q;
    hold_data_d = hold_data_q;
    we_d = 1'b0;
    mis_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (mem_valid) begin
      waddr_d = mem_rd;
      wdata_d = ld;
      we_d = !mis && mem_rd != '0;
      mis_d = mis;
      if (acc) begin
        state_d = HOLD;
        hold_rd_d = ex_rd;
        hold_data_d = ex_data;
      end else if (state_q == HOLD && !mis && mem_rd == hold_rd_q) begin
        state_d = IDLE;
      end
    end else if (state_q == HOLD) begin
      waddr_d = hold_rd_q;
      wdata_d = hold_data_q;
      we_d = hold_rd_q != '0;
      state_d = IDLE;
    end else if (acc) begin
      waddr_d = ex_rd;
      wdata_d = ex_data;
      we_d = ex_rd != '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_rd_q <= '0;
      hold_data_q <= '0;
      we_q <= 1'b0;
      mis_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      hold_rd_q <= hold_rd_d;
      hold_data_q <= hold_data_d;
      we_q <= we_d;
      mis_q <= mis_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
  assign rf_we = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign mem_misalign = mis_q;
`ifdef WB_FWD_EN
  assign fwd1_valid = we_q && waddr_q == rs1_addr && rs1_addr != '0;
  assign fwd2_valid = we_q && waddr_q == rs2_addr && rs2_addr != '0;
  assign fwd1_data = wdata_q;
  assign fwd2_data = wdata_q;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: vector table, directed hazard sequences and randomized model check.
module tb_writeback_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ex_valid, ex_ready, mem_valid, mem_unsigned, rf_we, mem_misalign;
  logic [4:0]  ex_rd, mem_rd, rf_waddr;
  logic [31:0] ex_data, mem_data, rf_wdata;
  logic [1:0]  mem_size, mem_off;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  writeback_unit dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd),
    .ex_data(ex_data), .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_off(mem_off), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .mem_misalign(mem_misalign)
  );
  typedef struct {
    logic ev; logic [4:0] erd; logic [31:0] ed;
    logic mv; logic [4:0] mrd; logic [31:0] md; logic [1:0] sz; logic u; logic [1:0] off;
    logic we; logic [4:0] wa; logic [31:0] wd; logic mis; logic ckd;
  } vec_t;
  vec_t vecs[14];
  logic        hv, lk;
  logic [4:0]  hrd, la;
  logic [31:0] hd, ld;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic [1:0] sz, input logic u, input logic [1:0] off);
    ex_valid = ev; ex_rd = erd; ex_data = ed;
    mem_valid = mv; mem_rd = mrd; mem_data = md; mem_size = sz; mem_unsigned = u; mem_off = off;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  function automatic void fmt(input logic [31:0] d, input logic [1:0] s, input logic u,
                              input logic [1:0] o, output logic [31:0] v, output logic bad);
    int sh;
    sh = 8 * int'(o);
    bad = 1'b0;
    v = d;
    if (s == 2'd0) begin
      v = (d >> sh) % 256;
      if (!u && v >= 128) v = v - 256;
    end else if (s == 2'd1) begin
      bad = (o % 2) == 1;
      v = (d >> sh) % 65536;
      if (!u && v >= 32768) v = v - 65536;
    end else if (s == 2'd2) begin
      bad = o != 0;
    end else begin
      bad = 1'b1;
    end
  endfunction
  task automatic model(output logic we, output logic m);
    logic acc, fm;
    logic [31:0] f;
    acc = ex_valid && !hv;
    we = 1'b0;
    m = 1'b0;
    if (mem_valid) begin
      fmt(mem_data, mem_size, mem_unsigned, mem_off, f, fm);
      la = mem_rd; ld = f; lk = !fm; we = !fm && mem_rd != 0; m = fm;
      if (acc) begin
        hv = 1; hrd = ex_rd; hd = ex_data;
      end else if (hv && !fm && mem_rd == hrd) begin
        hv = 0;
      end
    end else if (hv) begin
      la = hrd; ld = hd; lk = 1; we = hrd != 0; hv = 0;
    end else if (acc) begin
      la = ex_rd; ld = ex_data; lk = 1; we = ex_rd != 0;
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    logic ewe, emis;
    vecs[0]  = '{1, 3, 32'h1234, 0, 0, 0, 0, 0, 0,                 1, 3, 32'h1234, 0, 1};
    vecs[1]  = '{0, 0, 0, 1, 7, 32'h0080_0000, 2'b00, 0, 2,        1, 7, 32'hFFFF_FF80, 0, 1};
    vecs[2]  = '{0, 0, 0, 1, 7, 32'h0080_0000, 2'b00, 1, 2,        1, 7, 32'h0000_0080, 0, 1};
    vecs[3]  = '{0, 0, 0, 1, 9, 32'h8001_1234, 2'b01, 0, 2,        1, 9, 32'hFFFF_8001, 0, 1};
    vecs[4]  = '{0, 0, 0, 1, 9, 32'h8001_1234, 2'b01, 1, 0,        1, 9, 32'h0000_1234, 0, 1};
    vecs[5]  = '{0, 0, 0, 1, 10, 32'hDEAD_BEEF, 2'b10, 0, 0,       1, 10, 32'hDEAD_BEEF, 0, 1};
    vecs[6]  = '{0, 0, 0, 1, 11, 32'h7F00_0000, 2'b00, 0, 3,       1, 11, 32'h0000_007F, 0, 1};
    vecs[7]  = '{0, 0, 0, 1, 12, 32'h0000_AB00, 2'b00, 0, 1,       1, 12, 32'hFFFF_FFAB, 0, 1};
    vecs[8]  = '{0, 0, 0, 1, 13, 32'h1111_2222, 2'b01, 0, 1,       0, 13, 0, 1, 0};
    vecs[9]  = '{0, 0, 0, 1, 14, 32'h1111_2222, 2'b10, 0, 2,       0, 14, 0, 1, 0};
    vecs[10] = '{0, 0, 0, 1, 15, 32'h1111_2222, 2'b11, 0, 0,       0, 15, 0, 1, 0};
    vecs[11] = '{1, 0, 32'h55, 0, 0, 0, 0, 0, 0,                   0, 0, 32'h55, 0, 1};
    vecs[12] = '{0, 0, 0, 1, 0, 32'h66, 2'b10, 0, 0,               0, 0, 32'h66, 0, 1};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h66, 0, 1};
    idle();
    #12;
    chk("reset_we", rf_we, 0);
    chk("reset_waddr", rf_waddr, 0);
    chk("reset_wdata", rf_wdata, 0);
    chk("reset_mis", mem_misalign, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_ready", ex_ready, 1);
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].ev, vecs[i].erd, vecs[i].ed, vecs[i].mv, vecs[i].mrd, vecs[i].md,
            vecs[i].sz, vecs[i].u, vecs[i].off);
      chk($sformatf("vec%0d_ready", i), ex_ready, 1);
      tick();
      chk($sformatf("vec%0d_we", i), rf_we, vecs[i].we);
      chk($sformatf("vec%0d_waddr", i), rf_waddr, vecs[i].wa);
      if (vecs[i].ckd) chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].wd);
      chk($sformatf("vec%0d_mis", i), mem_misalign, vecs[i].mis);
    end
    drive(1, 4, 32'hA, 1, 5, 32'hB, 2'b10, 0, 0);
    tick();
    idle();
    chk("conf_n1_we", rf_we, 1);
    chk("conf_n1_waddr", rf_waddr, 5);
    chk("conf_n1_wdata", rf_wdata, 32'hB);
    chk("conf_n1_ready", ex_ready, 0);
    tick();
    chk("conf_n2_we", rf_we, 1);
    chk("conf_n2_waddr", rf_waddr, 4);
    chk("conf_n2_wdata", rf_wdata, 32'hA);
    tick();
    chk("conf_n3_ready", ex_ready, 1);
    chk("conf_n3_we", rf_we, 0);
    drive(1, 4, 32'hA, 1, 5, 32'hB, 2'b10, 0, 0);
    tick();
    drive(0, 0, 0, 1, 4, 32'hC, 2'b10, 0, 0);
    chk("sup_hold_ready", ex_ready, 0);
    tick();
    idle();
    chk("sup_we", rf_we, 1);
    chk("sup_waddr", rf_waddr, 4);
    chk("sup_wdata", rf_wdata, 32'hC);
    chk("sup_ready", ex_ready, 1);
    tick();
    chk("sup_no_held_we", rf_we, 0);
    chk("sup_keep_wdata", rf_wdata, 32'hC);
    drive(1, 6, 32'h77, 1, 8, 32'h99, 2'b10, 0, 0);
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_hold_we", rf_we, 0);
    chk("rst_hold_waddr", rf_waddr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_hold_ready", ex_ready, 1);
    tick();
    chk("rst_hold_we1", rf_we, 0);
    tick();
    chk("rst_hold_we2", rf_we, 0);
    do_reset();
    hv = 0; hrd = 0; hd = 0; la = 0; ld = 0; lk = 1;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      chk("rnd_ready", ex_ready, !hv);
      model(ewe, emis);
      tick();
      chk("rnd_we", rf_we, ewe);
      chk("rnd_waddr", rf_waddr, la);
      if (lk) chk("rnd_wdata", rf_wdata, ld);
      chk("rnd_mis", mem_misalign, emis);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
